spi_write_controller: RTL and testbench

SPI_WRITE_CONTROLLER -- requirements
Module: spi_write_controller

---
 rtl/spi_write_controller_if.sv | 26 ++
 rtl/spi_write_controller.sv | 155 +++++++++++++++
 tb/tb_spi_write_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_write_controller_if.sv
// spi_write_controller_if
// Groups the request handshake and SPI pins of spi_write_controller.
//   start, addr[6:0], wdata[7:0] : frame request (requester -> controller)
//   busy, done                   : frame status (controller -> requester)
//   SCLK, COPI, nCS              : SPI mode-0 pins (controller -> peripheral)
// Modports: master = requester side, slave = controller side.
interface spi_write_controller_if;
    logic       start;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       COPI;
    logic       nCS;

    modport master (
        output start, addr, wdata,
        input  busy, done, SCLK, COPI, nCS
    );

    modport slave (
        input  start, addr, wdata,
        output busy, done, SCLK, COPI, nCS
    );
endinterface

// File: rtl/spi_write_controller.sv
// spi_write_controller
// Sends one 16-bit SPI mode-0 write frame {1'b1, addr, wdata}, MSB first,
// per accepted start. Every output is driven straight from a flop.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of spi_write_controller_if
//           (start/addr/wdata in; busy/done/SCLK/COPI/nCS out)
// CLK_DIV : SCLK half-period in clk cycles (2..255)
//
// state | meaning
// IDLE  | nCS high, waiting for start; done pulses here for one cycle
// SETUP | nCS low, COPI = bit15, SCLK low for one half-period
// SHIFT | 32 half-periods of SCLK; COPI advances on falling edges
// HOLD  | nCS low, SCLK low for one half-period after the last fall
// GAP   | nCS high, COPI low for one half-period before done
module spi_write_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_write_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic [15:0] sr, sr_nx;
    logic        sclk_q, sclk_nx;
    logic        copi_q, copi_nx;
    logic        ncs_q, ncs_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;
    logic        tc;

    // Half-period down-counter reaches its last cycle.
    assign tc = (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_cnt <= 4'd0;
            sr      <= 16'd0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            sr      <= sr_nx;
            sclk_q  <= sclk_nx;
            copi_q  <= copi_nx;
            ncs_q   <= ncs_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = tc ? DIV_LOAD : cnt - 8'd1;
        bit_cnt_nx = bit_cnt;
        sr_nx      = sr;
        sclk_nx    = sclk_q;
        copi_nx    = copi_q;
        ncs_nx     = ncs_q;
        busy_nx    = busy_q;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (bus.start) begin
                    state_nx   = SETUP;
                    cnt_nx     = DIV_LOAD;
                    bit_cnt_nx = 4'd0;
                    sr_nx      = {1'b1, bus.addr, bus.wdata};
                    copi_nx    = 1'b1;
                    ncs_nx     = 1'b0;
                    busy_nx    = 1'b1;
                end
            end
            SETUP: begin
                if (tc) begin
                    state_nx = SHIFT;
                    sclk_nx  = 1'b1;
                end
            end
            SHIFT: begin
                if (tc) begin
                    if (!sclk_q) begin
                        sclk_nx = 1'b1;
                    end else begin
                        sclk_nx = 1'b0;
                        // The 16th falling edge ends shifting; COPI keeps bit0.
                        if (bit_cnt == 4'd15) begin
                            state_nx = HOLD;
                        end else begin
                            bit_cnt_nx = bit_cnt + 4'd1;
                            sr_nx      = {sr[14:0], 1'b0};
                            copi_nx    = sr[14];
                        end
                    end
                end
            end
            HOLD: begin
                if (tc) begin
                    state_nx = GAP;
                    ncs_nx   = 1'b1;
                    copi_nx  = 1'b0;
                end
            end
            GAP: begin
                // busy drops together with done, so a start seen in the done
                // cycle is taken; back-to-back frames then see nCS high for
                // the GAP half-period plus the done cycle.
                if (tc) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                    sr_nx    = 16'd0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
                sclk_nx  = 1'b0;
                copi_nx  = 1'b0;
                ncs_nx   = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign bus.SCLK = sclk_q;
    assign bus.COPI = copi_q;
    assign bus.nCS  = ncs_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// tb_spi_write_controller
// Two controllers (CLK_DIV = 4 and CLK_DIV = 2). Drivers push the expected
// frame per accepted start; a negedge monitor rebuilds each frame from the
// pins and compares it against the queue head whenever done pulses.
module tb_spi_write_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_write_controller_if bus0 ();
    spi_write_controller_if bus1 ();

    spi_write_controller #(.CLK_DIV(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_write_controller #(.CLK_DIV(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [15:0] frame;
        int          t0;
        int          low;
        int          lat;
        int          first_rise;
        int          last_rise;
        int          gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic        p_sclk[2], p_copi[2], p_ncs[2], p_done[2];
    logic [15:0] bits[2];
    int          rises[2], low_m[2], viol[2], glitch[2];
    int          first_r[2], last_r[2], hi_len[2], rise_cyc[2], gap_m[2];

    task automatic mon_step(int i, logic sclk, logic copi, logic ncs, logic busy, logic done);
        exp_t e;
        bit   have;
        int   div;
        div = (i == 0) ? 4 : 2;
        if (!rst_n) begin
            rises[i]  = 0;
            low_m[i]  = 0;
            viol[i]   = 0;
            bits[i]   = 16'd0;
            hi_len[i] = 0;
        end else begin
            if (p_ncs[i] && !ncs) begin
                gap_m[i]   = cyc - rise_cyc[i];
                rises[i]   = 0;
                low_m[i]   = 0;
                viol[i]    = 0;
                bits[i]    = 16'd0;
                first_r[i] = -1;
                last_r[i]  = -1;
                hi_len[i]  = 0;
            end
            if (!p_ncs[i] && ncs) rise_cyc[i] = cyc;
            if (!ncs) low_m[i]++;
            if (ncs && (sclk || copi)) glitch[i]++;
            if (!p_sclk[i] && sclk) begin
                bits[i] = {bits[i][14:0], copi};
                rises[i]++;
                if (first_r[i] >= 0 && (cyc - last_r[i]) != 2 * div) viol[i]++;
                if (first_r[i] < 0) first_r[i] = cyc;
                last_r[i] = cyc;
            end
            if (sclk) hi_len[i]++;
            if (p_sclk[i] && !sclk) begin
                if (hi_len[i] != div) viol[i]++;
                hi_len[i] = 0;
            end
            // COPI may move only on an SCLK fall or together with nCS.
            if (copi != p_copi[i] && !(p_sclk[i] && !sclk) && (p_ncs[i] == ncs)) viol[i]++;
            if (done && p_done[i]) glitch[i]++;
            if (done) begin
                have = 1'b0;
                if (i == 0) begin
                    have = (q0.size() != 0);
                    if (have) e = q0.pop_front();
                end else begin
                    have = (q1.size() != 0);
                    if (have) e = q1.pop_front();
                end
                if (!have) begin
                    chk($sformatf("d%0d_unexpected_done", i), 1, 0);
                end else begin
                    chk($sformatf("d%0d_frame_bits", i), int'(bits[i]), int'(e.frame));
                    chk($sformatf("d%0d_sclk_rises", i), rises[i], 16);
                    chk($sformatf("d%0d_ncs_low_cycles", i), low_m[i], e.low);
                    chk($sformatf("d%0d_done_latency", i), cyc - e.t0, e.lat);
                    chk($sformatf("d%0d_first_rise", i), first_r[i] - e.t0, e.first_rise);
                    chk($sformatf("d%0d_last_rise", i), last_r[i] - e.t0, e.last_rise);
                    chk($sformatf("d%0d_timing_violations", i), viol[i], 0);
                    chk($sformatf("d%0d_busy_at_done", i), int'(busy), 0);
                    if (e.gap != 0) chk($sformatf("d%0d_ncs_high_gap", i), gap_m[i], e.gap);
                end
            end
        end
        p_sclk[i] = sclk;
        p_copi[i] = copi;
        p_ncs[i]  = ncs;
        p_done[i] = done;
    endtask

    always @(negedge clk) begin
        mon_step(0, bus0.SCLK, bus0.COPI, bus0.nCS, bus0.busy, bus0.done);
        mon_step(1, bus1.SCLK, bus1.COPI, bus1.nCS, bus1.busy, bus1.done);
    end

    // ---------------- drivers ----------------
    function automatic logic busy_of(int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic drive(int d, logic s, logic [6:0] a, logic [7:0] w);
        if (d == 0) begin
            bus0.start = s; bus0.addr = a; bus0.wdata = w;
        end else begin
            bus1.start = s; bus1.addr = a; bus1.wdata = w;
        end
    endtask

    // Hand-derived timing: D=4 -> nCS low 132, done at +137, rises at +5..+125;
    // D=2 -> nCS low 66, done at +69, rises at +3..+63.
    task automatic push(int d, logic [15:0] frame, int t0, int gap);
        exp_t e;
        e.frame = frame;
        e.t0    = t0;
        e.gap   = gap;
        if (d == 0) begin
            e.low = 132; e.lat = 137; e.first_rise = 5; e.last_rise = 125;
            q0.push_back(e);
        end else begin
            e.low = 66; e.lat = 69; e.first_rise = 3; e.last_rise = 63;
            q1.push_back(e);
        end
    endtask

    task automatic wait_idle(int d);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_of(d) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy_of(d)) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send(int d, logic [6:0] a, logic [7:0] w, logic [15:0] frame,
                        int gap, output int t0);
        wait_idle(d);
        drive(d, 1'b1, a, w);
        t0 = cyc;
        push(d, frame, t0, gap);
        @(negedge clk);
        drive(d, 1'b0, a, w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if ((q0.size() + q1.size()) != 0) begin
            chk("drain_timeout", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        drive(0, 1'b0, 7'h00, 8'h00);
        drive(1, 1'b0, 7'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ncs", int'(bus0.nCS), 1);
        chk("reset_sclk", int'(bus0.SCLK), 0);
        chk("reset_copi", int'(bus0.COPI), 0);
        chk("reset_busy", int'(bus0.busy), 0);
        chk("reset_done", int'(bus0.done), 0);
        chk("reset_ncs_d2", int'(bus1.nCS), 1);
        rst_n = 1'b1;

        // addr 0x00 / 0xA5
        send(0, 7'h00, 8'hA5, 16'h80A5, 0, t0);
        drain();

        // all-ones then all-zeros payload, second start taken in the done cycle
        send(0, 7'h7F, 8'hFF, 16'hFFFF, 0, t0);
        send(0, 7'h00, 8'h00, 16'h8000, 5, t0);
        drain();

        // start held high across two frames; nCS-high gap = GAP + done cycle
        wait_idle(0);
        drive(0, 1'b1, 7'h04, 8'h3C);
        t0 = cyc;
        push(0, 16'h843C, t0, 0);
        @(negedge clk);
        drive(0, 1'b1, 7'h01, 8'h81);
        push(0, 16'h8181, t0 + 137, 5);
        wait_until(t0 + 137);
        @(negedge clk);
        drive(0, 1'b0, 7'h01, 8'h81);
        drain();

        // starts and input changes mid-frame are ignored
        send(0, 7'h02, 8'h3C, 16'h823C, 0, t0);
        wait_until(t0 + 10);
        drive(0, 1'b1, 7'h55, 8'h0F);
        @(negedge clk);
        drive(0, 1'b0, 7'h33, 8'hF0);
        wait_until(t0 + 50);
        drive(0, 1'b1, 7'h7F, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 7'h2A, 8'hC3);
        wait_until(t0 + 100);
        drive(0, 1'b1, 7'h11, 8'h99);
        @(negedge clk);
        drive(0, 1'b0, 7'h00, 8'h00);
        drain();
        repeat (150) @(negedge clk);

        // reset mid-frame aborts with no done; next frame (addr 0x7E) is complete
        send(0, 7'h05, 8'h66, 16'h8566, 0, t0);
        wait_until(t0 + 60);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ncs", int'(bus0.nCS), 1);
        chk("abort_sclk", int'(bus0.SCLK), 0);
        chk("abort_copi", int'(bus0.COPI), 0);
        chk("abort_busy", int'(bus0.busy), 0);
        chk("abort_done", int'(bus0.done), 0);
        void'(q0.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(0, 7'h7E, 8'h18, 16'hFE18, 0, t0);
        drain();

        // minimum divider
        send(1, 7'h03, 8'h5A, 16'h835A, 0, t0);
        drain();
        repeat (150) @(negedge clk);

        chk("d0_idle_pin_glitches", glitch[0], 0);
        chk("d1_idle_pin_glitches", glitch[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
